bin2bcd_seq: RTL
================

Name: bin2bcd_seq

Overview:
- Parametrised, multi-cycle binary-to-BCD converter using iterative shift-add-3 (double-dabble).
- Accepts a BIN_W-bit unsigned value over a valid/ready handshake and returns DIGITS packed BCD digits, an overflow flag and a leading-zero blanking mask.
- Sits between datapath counters and the LED digit drivers. Replaces fixed-width case-table converters for any input width or display size.

Parameters:
- BIN_W, 8, binary input width; legal range 1..32.
- DIGITS, 3, number of BCD output digits; legal range 1..10.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  bin is valid this cycle.
- in_ready  out  1  converter can accept a value.
- bin  in  BIN_W  unsigned binary input.
- lz_en  in  1  leading-zero blanking enable; sampled with bin.
- out_valid  out  1  result is valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- bcd  out  4*DIGITS  packed BCD; digit i is bcd[4i+3:4i], digit 0 is least significant.
- ovf  out  1  input exceeded 10^DIGITS-1.
- blank  out  DIGITS  per-digit blank request for the display.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, out_valid=0, bcd=0, ovf=0, blank=0. in_ready is 0 while rst=1.
- Reset has priority over every other event. Asserting rst mid-conversion abandons the conversion with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture bin into the shift register, capture lz_en, clear the BCD register and ovf, load count=BIN_W, go to SHIFT.
- SHIFT (in_ready=0), one step per edge:
  - Each digit >=5 gets +3, all digits in parallel.
  - Then shift {bcd, shift_reg} left by 1. The MSB of shift_reg enters bcd bit 0.
  - The bit shifted out of bcd MSB ORs into the sticky ovf.
  - count decrements. When count reaches 1 on this edge, go to DONE.
- DONE:
  - out_valid=1. bcd, ovf and blank are stable.
  - Leave on an edge with out_ready=1, returning to IDLE.
  - No new input is accepted in DONE, so in_ready=0.
- Latency: the accept edge is edge 0. Exactly BIN_W SHIFT edges follow, and out_valid is high from the cycle after edge BIN_W. The next accept can occur no earlier than the edge after the out_ready handshake, giving a minimum period of BIN_W+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, all outputs hold unchanged indefinitely.
- Overflow:
  - If ovf=1 at DONE, bcd reads all nines (0x9 per digit) instead of the truncated value.
  - ovf is exact: it is set if and only if bin > 10^DIGITS-1.
- Blanking:
  - blank[i]=1 if lz_en was captured as 1, ovf=0, i>=1, and digits i..DIGITS-1 are all zero.
  - blank[0] is always 0. blank is 0 whenever out_valid=0.
- Width rule: no internal arithmetic wider than 4 bits per digit. The digit adjust is a 4-bit compare plus add. count width is clog2(BIN_W+1).
- bin is sampled only on the accept edge. Changes on bin at other times have no effect.

Test Plan:
- BIN_W=8, DIGITS=3; bin=255, lz_en=0, out_ready=1 -> out_valid at cycle 9 after accept; bcd=0x255, ovf=0, blank=000.
- BIN_W=8, DIGITS=3; bin=7, lz_en=1 -> bcd=0x007, blank=110. Repeat with bin=0, lz_en=1 -> bcd=0x000, blank=110.
- BIN_W=8, DIGITS=2:
  - bin=100 -> ovf=1, bcd=0x99, blank=00.
  - bin=99 -> ovf=0, bcd=0x99.
  - bin=255 -> ovf=1, bcd=0x99.
- BIN_W=4, DIGITS=2; sweep bin=0..15 -> bcd = 0x00..0x09, then 0x10..0x15; ovf=0 throughout.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs constant and in_ready=0. Pulse out_ready -> IDLE next cycle with in_ready=1. Issue a back-to-back second input; it is accepted on the first IDLE edge.
- Reset: assert rst for 1 cycle at SHIFT step 4 -> next cycle out_valid=0, bcd=0, ovf=0, in_ready=1 after rst drops. A fresh conversion of 128 then yields 0x128 with no contamination from the aborted value.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter (shift-add-3) with valid/ready handshake,
// exact overflow detection and leading-zero blanking mask.
module bin2bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  input  logic                  lz_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(BIN_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]          state;
  logic [BIN_W-1:0]    sreg;
  logic [4*DIGITS-1:0] bcd_r;
  logic [4*DIGITS-1:0] bcd_adj;
  logic                ovf_r;
  logic                lz_r;
  logic [CW-1:0]       count;
  logic                zero_above;

  always_comb begin
    bcd_adj = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_r[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = bcd_r[4*i +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      bcd_r <= '0;
      ovf_r <= 1'b0;
      lz_r  <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= bin;
            lz_r  <= lz_en;
            bcd_r <= '0;
            ovf_r <= 1'b0;
            count <= CW'(BIN_W);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          // The adjusted top-digit MSB falls off the register; any 1 seen there
          // means the running prefix already reached 10^DIGITS, so it is sticky.
          bcd_r <= {bcd_adj[4*DIGITS-2:0], sreg[BIN_W-1]};
          sreg  <= sreg << 1;
          ovf_r <= ovf_r | bcd_adj[4*DIGITS-1];
          count <= count - CW'(1);
          if (count == CW'(1))
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign ovf       = ovf_r;
  assign bcd       = ovf_r ? {DIGITS{4'h9}} : bcd_r;

  // Scan from the most significant digit down; a digit blanks only while
  // everything above it (and itself) is zero. Digit 0 never blanks.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (bcd_r[4*i +: 4] == 4'd0);
      blank[i]   = out_valid && lz_r && !ovf_r && zero_above;
    end
  end

endmodule
